// File: rtl/dmem_wait_resp_if.sv
// Load/store bus between the core's data port and dmem_wait_resp, plus the
// shared access-type and error-code enums used on that bus.
package dmem_wait_resp_pkg;
   typedef enum logic [2:0] {
      MEM_DT_BYTE  = 3'd0,
      MEM_DT_UBYTE = 3'd1,
      MEM_DT_HALF  = 3'd2,
      MEM_DT_UHALF = 3'd3,
      MEM_DT_WORD  = 3'd4
   } mem_dt_e;

   typedef enum logic [1:0] {
      ENONE  = 2'd0,
      EALIGN = 2'd1,
      EADDR  = 2'd2
   } errno_e;
endpackage

interface dmem_wait_resp_if;
   import dmem_wait_resp_pkg::*;

   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wd;
   mem_dt_e     dt;
   logic        ack;
   logic [31:0] rd;
   errno_e      err;
   logic        busy;

   modport master (output req, addr, we, wd, dt, input ack, rd, err, busy);
   modport slave  (input req, addr, we, wd, dt, output ack, rd, err, busy);
endinterface

// File: rtl/dmem_wait_resp.sv
// Data-side RAM responder: req/ack slave with WAIT_CYC wait states, byte/half/word
// access with alignment and range faults. Define DMEM_WAIT_RESP_STATS_EN for access counters.
module dmem_wait_resp
   import dmem_wait_resp_pkg::*;
#(
   parameter int          N_WORDS   = 64,
   parameter int          WAIT_CYC  = 2,
   parameter logic [31:0] BASE_ADDR = 32'h00000000
) (
   input  logic           clk,
   input  logic           rst,
   dmem_wait_resp_if.slave bus
`ifdef DMEM_WAIT_RESP_STATS_EN
   ,
   output logic [15:0]    rd_cnt,
   output logic [15:0]    wr_cnt,
   output logic [15:0]    err_cnt
`endif
);

   localparam int          AW          = $clog2(N_WORDS);
   localparam logic [31:0] RANGE_BYTES = 32'(4 * N_WORDS);
   localparam logic [3:0]  WAIT_INIT   = 4'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT, S_RESP} state_e;

   state_e      state;
   logic [31:0] cap_addr;
   logic        cap_we;
   logic [31:0] cap_wd;
   mem_dt_e     cap_dt;
   logic [3:0]  wait_cnt;
   logic        ack_q;
   errno_e      err_q;
   logic        busy_q;

   logic [31:0] mem [N_WORDS];
   logic [31:0] off;
   logic [AW-1:0] word_idx;
   logic [31:0] rd_word;
   logic [31:0] wr_word;
   logic [31:0] load_val;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   errno_e      chk_err;

   // Unsigned subtraction makes addresses below BASE_ADDR wrap to huge offsets.
   assign off      = cap_addr - BASE_ADDR;
   assign word_idx = off[AW+1:2];
   assign rd_word  = mem[word_idx];
   assign byte_sel = rd_word[{cap_addr[1:0], 3'b000} +: 8];
   assign half_sel = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      chk_err = ENONE;
      case (cap_dt)
         MEM_DT_BYTE, MEM_DT_UBYTE: chk_err = ENONE;
         MEM_DT_HALF, MEM_DT_UHALF: if (cap_addr[0]) chk_err = EALIGN;
         default:                   if (cap_addr[1:0] != 2'b00) chk_err = EALIGN;
      endcase
      if (chk_err == ENONE && off >= RANGE_BYTES) chk_err = EADDR;
   end

   always_comb begin
      load_val = rd_word;
      case (cap_dt)
         MEM_DT_BYTE:  load_val = {{24{byte_sel[7]}}, byte_sel};
         MEM_DT_UBYTE: load_val = {24'h000000, byte_sel};
         MEM_DT_HALF:  load_val = {{16{half_sel[15]}}, half_sel};
         MEM_DT_UHALF: load_val = {16'h0000, half_sel};
         default:      load_val = rd_word;
      endcase
   end

   always_comb begin
      wr_word = rd_word;
      case (cap_dt)
         MEM_DT_BYTE, MEM_DT_UBYTE: wr_word[{cap_addr[1:0], 3'b000} +: 8]  = cap_wd[7:0];
         MEM_DT_HALF, MEM_DT_UHALF: wr_word[{cap_addr[1], 4'b0000} +: 16] = cap_wd[15:0];
         default:                   wr_word = cap_wd;
      endcase
   end

   // RAM has no reset; a reset in flight leaves state IDLE so no write fires.
   always_ff @(posedge clk) begin
      if (state == S_RESP && cap_we && err_q == ENONE) mem[word_idx] <= wr_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cap_addr <= '0;
         cap_we   <= 1'b0;
         cap_wd   <= '0;
         cap_dt   <= MEM_DT_WORD;
         wait_cnt <= '0;
         ack_q    <= 1'b0;
         err_q    <= ENONE;
         busy_q   <= 1'b0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.req) begin
                  cap_addr <= bus.addr;
                  cap_we   <= bus.we;
                  cap_wd   <= bus.wd;
                  cap_dt   <= bus.dt;
                  busy_q   <= 1'b1;
                  state    <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (chk_err != ENONE || WAIT_CYC == 0) begin
                  err_q <= chk_err;
                  ack_q <= 1'b1;
                  state <= S_RESP;
               end else begin
                  wait_cnt <= WAIT_INIT;
                  state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  err_q <= ENONE;
                  ack_q <= 1'b1;
                  state <= S_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            S_RESP: begin
               busy_q <= 1'b0;
               err_q  <= ENONE;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.ack  = ack_q;
   assign bus.err  = err_q;
   assign bus.busy = busy_q;
   assign bus.rd   = (state == S_RESP && !cap_we && err_q == ENONE) ? load_val : 32'h0;

`ifdef DMEM_WAIT_RESP_STATS_EN
   // Saturating counters; a faulted access counts only as an error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt  <= '0;
         wr_cnt  <= '0;
         err_cnt <= '0;
      end else if (ack_q) begin
         if (err_q != ENONE) begin
            if (err_cnt != 16'hffff) err_cnt <= err_cnt + 16'd1;
         end else if (cap_we) begin
            if (wr_cnt != 16'hffff) wr_cnt <= wr_cnt + 16'd1;
         end else begin
            if (rd_cnt != 16'hffff) rd_cnt <= rd_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dmem_wait_resp.sv
// Directed bench for dmem_wait_resp (WAIT_CYC=2, N_WORDS=64, BASE_ADDR=0).
module tb_dmem_wait_resp;
   import dmem_wait_resp_pkg::*;

   localparam int WAIT_CYC = 2;

   logic clk;
   logic rst;
   int   errCount;
   int   checkCount;

   dmem_wait_resp_if bus ();

`ifdef DMEM_WAIT_RESP_STATS_EN
   logic [15:0] rdCnt, wrCnt, errCnt;
`endif

   dmem_wait_resp #(
      .N_WORDS  (64),
      .WAIT_CYC (WAIT_CYC),
      .BASE_ADDR(32'h00000000)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus)
`ifdef DMEM_WAIT_RESP_STATS_EN
      ,
      .rd_cnt (rdCnt),
      .wr_cnt (wrCnt),
      .err_cnt(errCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One transaction; scramble drops req and corrupts the bus right after capture.
   task automatic applyStimulus(input string tag, input logic isStore, input logic [31:0] a,
                                input logic [31:0] d, input mem_dt_e t, input logic scramble,
                                input logic [1:0] expErr, input logic [31:0] expRd);
      int          lat;
      int          expLat;
      logic [31:0] rdObs;
      logic [1:0]  errObs;
      expLat = (expErr != 2'd0) ? 1 : WAIT_CYC + 1;
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = isStore;
      bus.addr = a;
      bus.wd   = d;
      bus.dt   = t;
      @(posedge clk);
      #1;
      checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd1);
      if (scramble) begin
         bus.req  = 1'b0;
         bus.addr = ~a;
         bus.wd   = ~d;
         bus.dt   = MEM_DT_UBYTE;
      end
      lat    = -1;
      rdObs  = '0;
      errObs = '0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack) begin
            lat    = i;
            rdObs  = bus.rd;
            errObs = bus.err;
            break;
         end
      end
      bus.req = 1'b0;
      checkOutput({tag, ".lat"}, 32'(lat), 32'(expLat));
      checkOutput({tag, ".err"}, 32'(errObs), 32'(expErr));
      if (!isStore) checkOutput({tag, ".rd"}, rdObs, expRd);
      @(posedge clk);
      #1;
      checkOutput({tag, ".ackEnd"}, 32'(bus.ack), 32'd0);
      checkOutput({tag, ".busyEnd"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int ackCnt, ack1, ack2, fallAt, rise2, ackSeen;
      logic prevBusy;
      errCount   = 0;
      checkCount = 0;
      rst        = 1'b0;
      bus.req    = 1'b0;
      bus.we     = 1'b0;
      bus.addr   = '0;
      bus.wd     = '0;
      bus.dt     = MEM_DT_WORD;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst.ack", 32'(bus.ack), 32'd0);
      checkOutput("rst.rd", bus.rd, 32'd0);
      checkOutput("rst.err", 32'(bus.err), 32'd0);
      checkOutput("rst.busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      applyStimulus("stW8", 1'b1, 32'h8, 32'hdeadbeef, MEM_DT_WORD, 1'b1, 2'd0, 32'h0);
      applyStimulus("ldW8", 1'b0, 32'h8, 32'h0, MEM_DT_WORD, 1'b1, 2'd0, 32'hdeadbeef);

      applyStimulus("clrW8", 1'b1, 32'h8, 32'h00000000, MEM_DT_WORD, 1'b0, 2'd0, 32'h0);
      applyStimulus("stB9", 1'b1, 32'h9, 32'hffffff80, MEM_DT_BYTE, 1'b0, 2'd0, 32'h0);
      applyStimulus("ldB9", 1'b0, 32'h9, 32'h0, MEM_DT_BYTE, 1'b0, 2'd0, 32'hffffff80);
      applyStimulus("ldUB9", 1'b0, 32'h9, 32'h0, MEM_DT_UBYTE, 1'b0, 2'd0, 32'h00000080);
      applyStimulus("ldW8b", 1'b0, 32'h8, 32'h0, MEM_DT_WORD, 1'b0, 2'd0, 32'h00008000);
      applyStimulus("ldH8", 1'b0, 32'h8, 32'h0, MEM_DT_HALF, 1'b0, 2'd0, 32'hffff8000);
      applyStimulus("ldUH8", 1'b0, 32'h8, 32'h0, MEM_DT_UHALF, 1'b0, 2'd0, 32'h00008000);
      applyStimulus("stHa", 1'b1, 32'ha, 32'h1234abcd, MEM_DT_HALF, 1'b0, 2'd0, 32'h0);
      applyStimulus("ldW8c", 1'b0, 32'h8, 32'h0, MEM_DT_WORD, 1'b0, 2'd0, 32'habcd8000);

      applyStimulus("stW4", 1'b1, 32'h4, 32'h11223344, MEM_DT_WORD, 1'b0, 2'd0, 32'h0);
      applyStimulus("ldH3", 1'b0, 32'h3, 32'h0, MEM_DT_HALF, 1'b0, 2'd1, 32'h0);
      applyStimulus("stW6", 1'b1, 32'h6, 32'hffffffff, MEM_DT_WORD, 1'b0, 2'd1, 32'h0);
      applyStimulus("ldW4", 1'b0, 32'h4, 32'h0, MEM_DT_WORD, 1'b0, 2'd0, 32'h11223344);

      applyStimulus("stW0", 1'b1, 32'h0, 32'ha5a5a5a5, MEM_DT_WORD, 1'b0, 2'd0, 32'h0);
      applyStimulus("stW100", 1'b1, 32'h100, 32'h55555555, MEM_DT_WORD, 1'b0, 2'd2, 32'h0);
      applyStimulus("ldW0", 1'b0, 32'h0, 32'h0, MEM_DT_WORD, 1'b0, 2'd0, 32'ha5a5a5a5);
      applyStimulus("stWfc", 1'b1, 32'hfc, 32'hcafef00d, MEM_DT_WORD, 1'b0, 2'd0, 32'h0);
      applyStimulus("ldWfc", 1'b0, 32'hfc, 32'h0, MEM_DT_WORD, 1'b0, 2'd0, 32'hcafef00d);

      // req held high across two loads
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = 32'h8;
      bus.dt   = MEM_DT_WORD;
      ackCnt   = 0;
      ack1     = -1;
      ack2     = -1;
      fallAt   = -1;
      rise2    = -1;
      prevBusy = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack) begin
            ackCnt++;
            if (ack1 < 0) ack1 = i;
            else if (ack2 < 0) ack2 = i;
         end
         if (prevBusy && !bus.busy && fallAt < 0) fallAt = i;
         if (!prevBusy && bus.busy && fallAt >= 0 && rise2 < 0) rise2 = i;
         prevBusy = bus.busy;
         if (ack2 >= 0) begin
            bus.req = 1'b0;
            break;
         end
      end
      bus.req = 1'b0;
      checkOutput("b2b.ackCnt", 32'(ackCnt), 32'd2);
      checkOutput("b2b.ack1", 32'(ack1), 32'd4);
      checkOutput("b2b.idleGap", 32'(rise2 - fallAt), 32'd1);
      checkOutput("b2b.ackGap", 32'(ack2 - ack1), 32'd5);
      @(posedge clk);
      #1;
      checkOutput("b2b.ackEnd", 32'(bus.ack), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("b2b.busyEnd", 32'(bus.busy), 32'd0);

      // reset during WAIT of a store
      @(negedge clk);
      bus.req  = 1'b1;
      bus.we   = 1'b1;
      bus.addr = 32'h0;
      bus.wd   = 32'h12345678;
      bus.dt   = MEM_DT_WORD;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst     = 1'b0;
      bus.req = 1'b0;
      #1;
      checkOutput("rstMid.busy", 32'(bus.busy), 32'd0);
      ackSeen = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack) ackSeen++;
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack) ackSeen++;
      end
      checkOutput("rstMid.noAck", 32'(ackSeen), 32'd0);
`ifdef DMEM_WAIT_RESP_STATS_EN
      checkOutput("rstMid.wrCnt", 32'(wrCnt), 32'd0);
`endif
      applyStimulus("ldW0post", 1'b0, 32'h0, 32'h0, MEM_DT_WORD, 1'b0, 2'd0, 32'ha5a5a5a5);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule

// File: doc/dmem_wait_resp.md
Name: dmem_wait_resp

Overview:
- Data-side memory responder for the RISC-V core's load/store bus.
- Slave end of a req/ack protocol with a parameterised number of wait states, which exercises a multi-cycle data path.
- Holds a word-organised RAM and services byte/half/word accesses (mem_dt_e), signed and unsigned.
- Reports alignment and range faults via errno_e.
- Sits between the core's data port and the instruction/data memory subsystem.

Parameters:
- N_WORDS, 64, RAM depth in 32-bit words; must be a power of two.
- WAIT_CYC, 2, wait states between request capture and ack; legal range 0..15.
- BASE_ADDR, 32'h00000000, byte address of RAM word 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  request valid; held high by initiator until ack.
- addr  in  32  byte address.
- we  in  1  1 = store, 0 = load.
- wd  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- dt  in  mem_dt_e  access type: MEM_DT_BYTE, MEM_DT_UBYTE, MEM_DT_HALF, MEM_DT_UHALF, MEM_DT_WORD.
- ack  out  1  one-cycle completion pulse.
- rd  out  32  load data, extended, valid while ack=1.
- err  out  errno_e  ENONE, EALIGN or EADDR, valid while ack=1.
- busy  out  1  high from capture until the cycle after ack.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, ack=0, rd=0, err=ENONE, busy=0, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE -> (CHECK) -> WAIT -> RESP -> IDLE.
- IDLE, req=1 at an edge: capture addr/we/wd/dt into internal registers; busy=1.
- Fault checks (on the captured request):
  - EALIGN: half with addr[0]!=0, or word with addr[1:0]!=0.
  - EADDR: addr-BASE_ADDR >= 4*N_WORDS, using unsigned 32-bit arithmetic. A wrap below BASE_ADDR counts as out of range.
  - Alignment takes priority over range.
- Fault present: skip WAIT and go to RESP the next cycle. No RAM write; rd=0.
- No fault: WAIT for exactly WAIT_CYC cycles; WAIT_CYC=0 goes straight to RESP.
- RESP: ack=1 for exactly one cycle; err=ENONE on success.
  - Stores update the RAM on the RESP edge.
  - Loads present rd combinationally from RAM during RESP.
- Latency: ack rises WAIT_CYC+1 cycles after the capture edge (fault: 1 cycle).
- After RESP: return to IDLE with busy=0. The earliest next capture is the edge after busy drops, so there is one idle cycle between transactions; req still high in that cycle counts as a new request.
- req dropping mid-transaction does not abort; the transaction completes and ack pulses.
- addr/wd/dt changing after capture is ignored.
- Store lane merge (word index = (addr-BASE_ADDR)>>2):
  - byte: write wd[7:0] into lane addr[1:0].
  - half: write wd[15:0] into lane addr[1].
  - word: write full 32 bits.
  - Other lanes are preserved.
- Load extract: select lane by addr[1:0]/addr[1].
  - MEM_DT_BYTE/MEM_DT_HALF: sign-extend.
  - MEM_DT_UBYTE/MEM_DT_UHALF: zero-extend.
  - MEM_DT_WORD: raw word.
- Async reset mid-transaction: return to IDLE immediately; no write occurs and no ack is produced.
- Illegal dt encoding: treated as MEM_DT_WORD.

Optional Feature:
- Macro: DMEM_WAIT_RESP_STATS_EN.
- Defined: adds outputs rd_cnt, wr_cnt, err_cnt (16 bits each).
  - Each increments on an ack of the matching kind; faulted accesses count only in err_cnt.
  - Counters saturate at 16'hffff and reset to 0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- WAIT_CYC=2: store word 32'hdeadbeef at 0x8, then load word 0x8 -> each ack 3 cycles after capture; rd=32'hdeadbeef, err=ENONE.
- Store byte 8'h80 at 0x9 over 32'h00000000, then loads:
  - MEM_DT_BYTE @0x9 -> rd=32'hffffff80.
  - MEM_DT_UBYTE @0x9 -> rd=32'h00000080.
  - MEM_DT_WORD @0x8 -> rd=32'h00008000.
- Misaligned accesses:
  - Load half @0x3 -> ack 1 cycle after capture, err=EALIGN, rd=0.
  - Store word @0x6 -> err=EALIGN, RAM word 1 unchanged.
- Range, N_WORDS=64: store @0x100 -> err=EADDR, no write; load @0xfc -> err=ENONE.
- Back-to-back: req held high across two loads -> exactly one idle cycle between busy dropping and the second capture; two single-cycle ack pulses.
- Reset mid-WAIT of a store 32'h12345678 @0x0: pulse rst low -> ack never asserts; a following load @0x0 returns the prior contents. With the macro defined, wr_cnt=0.
